// File: rtl/density_pkg.sv
// Shared level encodings and default parameters for the lane density estimator.
package density_pkg;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_MED  = 2'd2,
        LVL_HIGH = 2'd3
    } level_t;

    localparam int DEF_WINDOW   = 1000;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_T1       = 4;
    localparam int DEF_T2       = 10;
    localparam int DEF_T3       = 20;
    localparam int DEF_HYST     = 2;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a run-length debouncer; pulses rise
// for one cycle on the same edge the stable level goes from 0 to 1.
module debounce_sync #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic detector,
    output logic rise
);

    localparam int RUN_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [RUN_W-1:0] run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            run    <= '0;
        end else begin
            sync_a <= detector;
            sync_b <= sync_a;
            rise   <= 1'b0;
            // Any cycle that agrees with the stable level restarts the run.
            if (sync_b == level) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                level <= sync_b;
                rise  <= sync_b;
                run   <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/density_estimator.sv
// Per-lane traffic density estimator: counts debounced vehicle events per
// fixed window and quantises the count to a 2-bit level with downgrade hysteresis.
module density_estimator
    import density_pkg::*;
#(
    parameter int WINDOW   = DEF_WINDOW,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T1       = DEF_T1,
    parameter int T2       = DEF_T2,
    parameter int T3       = DEF_T3,
    parameter int HYST     = DEF_HYST
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       detector,
    input  logic       enable,
    output logic [1:0] density,
    output logic       density_valid
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    function automatic level_t quantise(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(T3)) return LVL_HIGH;
        if (c >= CNT_W'(T2)) return LVL_MED;
        if (c >= CNT_W'(T1)) return LVL_LOW;
        return LVL_NONE;
    endfunction

    // Upgrades take effect at once; downgrades only once the count falls
    // HYST vehicles below the threshold of the current level.
    function automatic level_t next_level(input level_t cur, input logic [CNT_W-1:0] c);
        level_t up;
        level_t dn;
        up = quantise(c);
        dn = quantise(sat_add(c, CNT_W'(HYST)));
        if (up >= cur) return up;
        return (dn < cur) ? dn : cur;
    endfunction

    logic             vehicle;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] veh_cnt;
    level_t           level_q;
    logic             vld_p1;
    logic [CNT_W-1:0] cnt_p0;
    logic             close_p0;

    debounce_sync #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .detector (detector),
        .rise     (vehicle)
    );

    // Stage p0: count including this cycle's event, so a close-cycle event
    // lands in the closing window.
    assign cnt_p0   = sat_add(veh_cnt, CNT_W'(vehicle));
    assign close_p0 = enable && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt <= '0;
            veh_cnt <= '0;
            level_q <= LVL_NONE;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (close_p0) begin
                win_cnt <= '0;
                veh_cnt <= '0;
                level_q <= next_level(level_q, cnt_p0);
                vld_p1  <= 1'b1;
            end else if (enable) begin
                win_cnt <= win_cnt + 1'b1;
                veh_cnt <= cnt_p0;
            end
        end
    end

    // Stage p1: registered outputs, one cycle after the close cycle.
    assign density       = level_q;
    assign density_valid = vld_p1;

endmodule

// File: tb/tb_density_estimator.sv
// Directed bench for density_estimator with short windows and hand-derived levels.
module tb_density_estimator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       detector;
    logic       enable;
    logic [1:0] density;
    logic       density_valid;
    logic [1:0] density_w;
    logic       valid_w;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    always #5 clk = ~clk;

    density_estimator #(
        .WINDOW(16), .DEBOUNCE(2), .CNT_W(4), .T1(2), .T2(4), .T3(6), .HYST(1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .detector      (detector),
        .enable        (enable),
        .density       (density),
        .density_valid (density_valid)
    );

    // Longer window so five 4-high/4-low pulses fit inside one window.
    density_estimator #(
        .WINDOW(48), .DEBOUNCE(2), .CNT_W(4), .T1(2), .T2(4), .T3(6), .HYST(1)
    ) dut_wide (
        .clk           (clk),
        .reset_n       (reset_n),
        .detector      (detector),
        .enable        (enable),
        .density       (density_w),
        .density_valid (valid_w)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_to(input int n);
        while (t < n) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        detector = 1'b1;
        repeat (hi) tick();
        detector = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        t = 0;
    endtask

    initial begin
        detector = 1'b0;
        enable   = 1'b1;
        reset_n  = 1'b0;

        // Reset state and idle windows
        repeat (2) tick();
        chk("rst_density", density, 0);
        chk("rst_valid", density_valid, 0);
        reset_n = 1'b1;
        t = 0;
        wait_to(15); chk("idle_v15", density_valid, 0);
        wait_to(16); chk("idle_v16", density_valid, 1);
        chk("idle_d16", density, 0);
        wait_to(17); chk("idle_v17", density_valid, 0);
        wait_to(32); chk("idle_v32", density_valid, 1);
        chk("idle_d32", density, 0);

        // Clean traffic: five vehicles in one 48-cycle window
        do_reset();
        repeat (5) pulse(4, 4);
        wait_to(47); chk("clean_v47", valid_w, 0);
        wait_to(48); chk("clean_v48", valid_w, 1);
        chk("clean_d48", density_w, 2);

        // Glitch rejection
        do_reset();
        repeat (8) pulse(1, 1);
        wait_to(16); chk("glitch_v", density_valid, 1);
        chk("glitch_d", density, 0);

        // Build density 2 (last event on the close cycle), then hysteresis
        do_reset();
        wait_to(15);
        repeat (4) pulse(2, 2);
        wait_to(32); chk("hyst_v32", density_valid, 1);
        chk("hyst_d32", density, 2);
        repeat (3) pulse(2, 2);
        wait_to(48); chk("hyst_c3", density, 2);
        repeat (2) pulse(2, 2);
        wait_to(64); chk("hyst_c2", density, 1);
        wait_to(80); chk("hyst_c0", density, 0);

        // Close-cycle event: c=1 plus an event on the close cycle
        pulse(2, 2);
        wait_to(91);
        pulse(2, 2);
        wait_to(96); chk("close_v", density_valid, 1);
        chk("close_d", density, 1);
        wait_to(112); chk("close_next", density, 0);

        // Reset mid-window, then re-establish density 1
        wait_to(120);
        reset_n = 1'b0;
        #1;
        chk("async_d", density, 0);
        chk("async_v", density_valid, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        t = 0;
        wait_to(8);  chk("abort_v8", density_valid, 0);
        wait_to(15); chk("abort_v15", density_valid, 0);
        wait_to(16); chk("abort_v16", density_valid, 1);
        repeat (2) pulse(2, 2);
        wait_to(32); chk("pre_en_v", density_valid, 1);
        chk("pre_en_d", density, 1);

        // Enable low for 10 cycles, with a vehicle that must be discarded
        wait_to(36);
        enable = 1'b0;
        wait_to(37);
        pulse(2, 2);
        chk("en_hold_d41", density, 1);
        wait_to(46);
        enable = 1'b1;
        wait_to(48); chk("en_v48", density_valid, 0);
        chk("en_d48", density, 1);
        wait_to(57); chk("en_v57", density_valid, 0);
        chk("en_d57", density, 1);
        wait_to(58); chk("en_v58", density_valid, 1);
        chk("en_d58", density, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/density_estimator.md
DENSITY_ESTIMATOR -- requirements
Module: density_estimator

Interface
REQ-001 Parameter WINDOW, default 1000: window length in clk cycles, >= 2.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles required to accept a detector level change, >= 1.
REQ-003 Parameter CNT_W, default 8: vehicle-counter width.
REQ-004 Parameters T1, T2, T3, defaults 4, 10, 20: level thresholds, with 0 < T1 < T2 < T3 <= 2^CNT_W-1.
REQ-005 Parameter HYST, default 2: downgrade hysteresis margin in vehicles.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1 bit: reset is asynchronous and active-low.
REQ-008 Port detector, input, 1 bit: raw, asynchronous loop-detector signal for one lane.
REQ-009 Port enable, input, 1 bit: when high, the estimator counts and advances the window.
REQ-010 Port density, output, 2 bits: quantised lane density, 0 to 3, consumed as the lane's sensor input by the arbiter and lane FSM.
REQ-011 Port density_valid, output, 1 bit: one-cycle pulse marking a density update.

Function
REQ-012 detector shall pass through a 2-flop synchroniser before any other use.
REQ-013 Debounce: the stable level changes only after the synchronised value differs from it for DEBOUNCE consecutive cycles; any agreeing cycle restarts the run.
REQ-014 A vehicle event is a 0->1 transition of the stable level, and counts as one vehicle.
REQ-015 While enable=1:
- the window counter runs 0..WINDOW-1 and wraps;
- the cycle where it equals WINDOW-1 is the close cycle.
REQ-016 The vehicle count c increments per event and saturates at 2^CNT_W-1.
REQ-017 An event in the close cycle belongs to the closing window; c restarts at 0 in the next window.
REQ-018 up = 3 if c>=T3, 2 if c>=T2, 1 if c>=T1, else 0.
REQ-019 dn = the same function evaluated on min(c+HYST, 2^CNT_W-1).
REQ-020 New level = up if up >= current density; otherwise min(current density, dn).
REQ-021 density and density_valid shall be registered and update on the cycle after the close cycle (latency 1); density_valid is high for exactly that one cycle.
REQ-022 While enable=0:
- the window counter and c hold;
- density holds;
- density_valid is 0;
- synchroniser and debounce keep running, but events are discarded.
REQ-023 enable dropping during the close cycle suppresses that close; the window resumes at the held count.

Reset
REQ-024 While reset_n=0, all of the following are 0 asynchronously: density, density_valid, synchroniser flops, stable level, debounce run counter, window counter, c.
REQ-025 Reset mid-window discards the partial count; the first window after release spans a full WINDOW cycles.

Structure
REQ-026 Level encodings (LVL_NONE=0, LVL_LOW=1, LVL_MED=2, LVL_HIGH=3) and default thresholds shall live in the shared package density_pkg.
REQ-027 Synchroniser plus debounce shall be one sub-module, debounce_sync.
REQ-028 One instance serves one lane; the integration level instantiates one per approach (N, E).

Verification (WINDOW=16, DEBOUNCE=2, CNT_W=4, T1=2, T2=4, T3=6, HYST=1, enable=1)
REQ-029 Idle: no detector activity after reset -> density_valid pulses at cycles 16 and 32; density stays 0.
REQ-030 Clean traffic: 5 pulses (4 high/4 low) in one window -> density=2 one cycle after close.
REQ-031 Glitch rejection: 8 single-cycle pulses -> 0 events counted; density=0.
REQ-032 Hysteresis: from density=2, a window with c=3 keeps density at 2; the next window with c=2 gives density=1.
REQ-033 Close-cycle event: the event whose stable edge lands on the close cycle is counted. c=1 plus that event -> density=1; the next window starts at c=0.
REQ-034 Reset/enable: reset_n low mid-window -> density=0 immediately, with no density_valid for the aborted window. enable low for 10 cycles -> the close is delayed by 10 cycles and density holds throughout.
